// File: rtl/imm_extend_pkg.sv
// Shared immediate-extension definitions.
// Mode encodings are also used by the decode control unit.
package imm_extend_pkg;

    typedef enum logic [1:0] {
        IMM_ZERO   = 2'b00,
        IMM_SIGN   = 2'b01,
        IMM_UPPER  = 2'b10,
        IMM_BRANCH = 2'b11
    } imm_mode_e;

    localparam int IMM_IN_W     = 16;
    localparam int IMM_OUT_W    = 32;
    localparam int IMM_BR_SHIFT = 2;

endpackage

// File: rtl/imm_extend_core.sv
// Combinational immediate widening for the four extension modes.
// Every mode defines all output bits, including IN_WIDTH == OUT_WIDTH.
module imm_extend_core
    import imm_extend_pkg::*;
#(
    parameter int IN_WIDTH  = IMM_IN_W,
    parameter int OUT_WIDTH = IMM_OUT_W,
    parameter int BR_SHIFT  = IMM_BR_SHIFT
) (
    input  logic [IN_WIDTH-1:0]  in_i,
    input  logic [1:0]           mode_i,
    output logic [OUT_WIDTH-1:0] ext_o
);

    logic [OUT_WIDTH-1:0] zext;
    logic [OUT_WIDTH-1:0] sext;

    assign zext = OUT_WIDTH'(in_i);
    assign sext = OUT_WIDTH'($signed(in_i));

    always_comb begin
        ext_o = zext;
        unique case (imm_mode_e'(mode_i))
            IMM_ZERO:   ext_o = zext;
            IMM_SIGN:   ext_o = sext;
            IMM_UPPER:  ext_o = zext << (OUT_WIDTH - IN_WIDTH);
            IMM_BRANCH: ext_o = sext << BR_SHIFT;
            default:    ext_o = zext;
        endcase
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// Registered immediate-extension stage with valid/ready and a skid entry.
// InReady depends only on registered state, never on OutReady.
module imm_extend_pipe
    import imm_extend_pkg::*;
#(
    parameter int IN_WIDTH  = IMM_IN_W,
    parameter int OUT_WIDTH = IMM_OUT_W,
    parameter int BR_SHIFT  = IMM_BR_SHIFT
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Flush,
    input  logic                 InValid,
    output logic                 InReady,
    input  logic [IN_WIDTH-1:0]  In,
    input  logic [1:0]           Mode,
    output logic                 OutValid,
    input  logic                 OutReady,
    output logic [OUT_WIDTH-1:0] Out
);

    logic [OUT_WIDTH-1:0] ext;
    logic [OUT_WIDTH-1:0] out_q, out_d;
    logic [OUT_WIDTH-1:0] skid_q, skid_d;
    logic                 out_valid_q, out_valid_d;
    logic                 skid_valid_q, skid_valid_d;
    logic                 in_hs, out_hs;

    imm_extend_core #(
        .IN_WIDTH  (IN_WIDTH),
        .OUT_WIDTH (OUT_WIDTH),
        .BR_SHIFT  (BR_SHIFT)
    ) u_core (
        .in_i   (In),
        .mode_i (Mode),
        .ext_o  (ext)
    );

    assign in_hs  = InValid && !skid_valid_q;
    assign out_hs = out_valid_q && OutReady;

    always_comb begin
        out_d        = out_q;
        skid_d       = skid_q;
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        if (Flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q) begin
            if (in_hs) begin
                out_d       = ext;
                out_valid_d = 1'b1;
            end
        end else if (!skid_valid_q) begin
            if (in_hs && out_hs) begin
                out_d = ext;
            end else if (out_hs) begin
                out_valid_d = 1'b0;
            end else if (in_hs) begin
                skid_d       = ext;
                skid_valid_d = 1'b1;
            end
        end else if (out_hs) begin
            // Skid drains into the output register; order is preserved.
            out_d        = skid_q;
            skid_valid_d = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            out_q        <= out_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign InReady  = !skid_valid_q;
    assign OutValid = out_valid_q;
    assign Out      = out_q;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Self-checking bench: vector table, handshake corner sequences,
// randomized traffic against a queue model, and an 8->16 parameter sweep.
module tb_imm_extend_pipe;

    logic        Clk = 1'b0;
    logic        Reset, Flush, InValid, OutReady;
    logic        InReady, OutValid;
    logic [15:0] In;
    logic [1:0]  Mode;
    logic [31:0] Out;

    logic        Flush2, InValid2, OutReady2;
    logic        InReady2, OutValid2;
    logic [7:0]  In2;
    logic [1:0]  Mode2;
    logic [15:0] Out2;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    imm_extend_pipe #(.IN_WIDTH(16), .OUT_WIDTH(32), .BR_SHIFT(2)) dut (
        .Clk(Clk), .Reset(Reset), .Flush(Flush),
        .InValid(InValid), .InReady(InReady), .In(In), .Mode(Mode),
        .OutValid(OutValid), .OutReady(OutReady), .Out(Out)
    );

    imm_extend_pipe #(.IN_WIDTH(8), .OUT_WIDTH(16), .BR_SHIFT(1)) dut8 (
        .Clk(Clk), .Reset(Reset), .Flush(Flush2),
        .InValid(InValid2), .InReady(InReady2), .In(In2), .Mode(Mode2),
        .OutValid(OutValid2), .OutReady(OutReady2), .Out(Out2)
    );

    typedef struct {
        logic [15:0] in;
        logic [1:0]  mode;
        logic [31:0] exp;
    } vec_t;

    // Reference: plain integer arithmetic on the mode definitions.
    function automatic longint ref_ext(longint v, int mode, int iw, int ow, int bs);
        longint m, s, r;
        m = longint'(1) << ow;
        s = (v >= (longint'(1) << (iw - 1))) ? v - (longint'(1) << iw) : v;
        case (mode)
            0: r = v;
            1: r = s;
            2: r = v * (longint'(1) << (ow - iw));
            default: r = s * (longint'(1) << bs);
        endcase
        return ((r % m) + m) % m;
    endfunction

    task automatic chk(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    vec_t        vt[6];
    longint      q[$];
    logic [15:0] a, b, c;

    initial begin
        Reset = 1'b1; Flush = 1'b0; InValid = 1'b0; OutReady = 1'b1;
        In = '0; Mode = '0;
        Flush2 = 1'b0; InValid2 = 1'b0; OutReady2 = 1'b1;
        In2 = '0; Mode2 = '0;

        vt[0] = '{16'h8004, 2'b01, 32'hFFFF8004};
        vt[1] = '{16'h8004, 2'b00, 32'h00008004};
        vt[2] = '{16'h1234, 2'b10, 32'h12340000};
        vt[3] = '{16'hFFFF, 2'b11, 32'hFFFFFFFC};
        vt[4] = '{16'h7FFF, 2'b11, 32'h0001FFFC};
        vt[5] = '{16'h0005, 2'b01, 32'h00000005};

        step();
        step();
        chk("reset_inready", InReady, 1);
        Reset = 1'b0;
        chk("reset_outvalid", OutValid, 0);
        chk("reset_out", Out, 0);

        // Back-to-back through the draining path, one result per cycle.
        foreach (vt[i]) begin
            In = vt[i].in; Mode = vt[i].mode; InValid = 1'b1;
            step();
            chk($sformatf("vec%0d_valid", i), OutValid, 1);
            chk($sformatf("vec%0d_out", i), Out, vt[i].exp);
        end
        InValid = 1'b0;
        step();
        chk("vec_drain", OutValid, 0);

        // Backpressure: A, B, C with OutReady low.
        a = 16'h0011; b = 16'h0022; c = 16'h0033;
        OutReady = 1'b0; Mode = 2'b00; InValid = 1'b1;
        In = a; step();
        In = b; step();
        chk("full_inready", InReady, 0);
        In = c; step();
        chk("full_hold_out", Out, 32'h11);
        chk("full_c_refused", InReady, 0);
        InValid = 1'b0; OutReady = 1'b1;
        step();
        chk("drain_b", Out, 32'h22);
        chk("drain_b_valid", OutValid, 1);
        step();
        chk("drain_empty", OutValid, 0);
        In = c; InValid = 1'b1; step();
        InValid = 1'b0;
        chk("drain_c", Out, 32'h33);
        step();
        chk("drain_c_once", OutValid, 0);

        // Flush while FULL with a concurrent input.
        OutReady = 1'b0; InValid = 1'b1;
        In = a; step();
        In = b; step();
        Flush = 1'b1; In = c; step();
        Flush = 1'b0; InValid = 1'b0;
        chk("flush_outvalid", OutValid, 0);
        chk("flush_inready", InReady, 1);
        OutReady = 1'b1; step();
        chk("flush_nothing", OutValid, 0);

        // Reset in ONE with OutReady low.
        OutReady = 1'b0; In = a; InValid = 1'b1; step();
        InValid = 1'b0;
        chk("one_valid", OutValid, 1);
        Reset = 1'b1; step();
        chk("midreset_valid", OutValid, 0);
        chk("midreset_out", Out, 0);
        Reset = 1'b0; step();

        // Random traffic against a queue of outstanding results.
        q.delete();
        for (int n = 0; n < 400; n++) begin
            In       = 16'($urandom);
            Mode     = 2'($urandom_range(0, 3));
            InValid  = 1'($urandom_range(0, 1));
            OutReady = 1'($urandom_range(0, 3) != 0);
            Flush    = ($urandom_range(0, 19) == 0);
            #1;
            chk("rand_inready", InReady, q.size() < 2);
            chk("rand_outvalid", OutValid, q.size() > 0);
            if (q.size() > 0) chk("rand_out", Out, q[0]);
            @(posedge Clk);
            if (Flush) begin
                q.delete();
            end else begin
                if (OutValid && OutReady) void'(q.pop_front());
                if (InValid && InReady) q.push_back(ref_ext(longint'(In), int'(Mode), 16, 32, 2));
            end
            #1;
        end
        Flush = 1'b0; InValid = 1'b0;

        // Parameter sweep instance: 8 -> 16, branch shift 1.
        InValid2 = 1'b1; In2 = 8'h80;
        Mode2 = 2'b01; step();
        chk("p8_sign", Out2, 16'hFF80);
        Mode2 = 2'b11; step();
        chk("p8_branch", Out2, 16'hFF00);
        Mode2 = 2'b10; step();
        chk("p8_upper", Out2, 16'h8000);
        In2 = 8'h7F; Mode2 = 2'b11; step();
        chk("p8_branch_pos", Out2, ref_ext(64'h7F, 3, 8, 16, 1));
        InValid2 = 1'b0; step();
        chk("p8_drain", OutValid2, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/imm_extend_pipe.md
# imm_extend_pipe

Parametrised, registered immediate-extension stage for the datapath. It widens an IN_WIDTH-bit immediate to OUT_WIDTH bits under one of four modes: zero, sign, upper-load, or scaled-branch. It carries a valid/ready handshake with a one-entry skid buffer, so decode can stall or flush without losing or duplicating an immediate. It sits between instruction decode and the ID/EX boundary and drives the ALU B-operand mux and the branch-target adder.

## Interface
- IN_WIDTH, 16, immediate width; legal range 1 ≤ IN_WIDTH ≤ OUT_WIDTH.
- OUT_WIDTH, 32, extended result width.
- BR_SHIFT, 2, left-shift amount in branch mode; legal range 0 ≤ BR_SHIFT < OUT_WIDTH.
- Clk  input  1  clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- Flush  input  1  synchronous; discards all held data.
- InValid  input  1  upstream presents an immediate.
- InReady  output  1  block can accept an immediate this cycle.
- In  input  IN_WIDTH  raw immediate.
- Mode  input  2  extension mode: 00 zero, 01 sign, 10 upper, 11 branch.
- OutValid  output  1  Out holds a valid result.
- OutReady  input  1  downstream accepts Out this cycle.
- Out  output  OUT_WIDTH  extended immediate.

## Operation
- Extension is combinational on the In/Mode pair being captured:
  - zero: {0…, In}.
  - sign: In[IN_WIDTH-1] replicated into the upper OUT_WIDTH-IN_WIDTH bits.
  - upper: In placed in the top IN_WIDTH bits, low bits 0. When IN_WIDTH == OUT_WIDTH, upper equals zero mode.
  - branch: sign-extend, then shift left by BR_SHIFT. Bits shifted past the MSB are discarded.
- Every mode defines every output bit for every In value. No latches and no hold-previous behaviour.
- Storage: output register (OutReg, OutValid) plus one skid entry (SkidReg, SkidValid).
- Transfer rules:
  - An input handshake occurs when InValid && InReady.
  - An output handshake occurs when OutValid && OutReady.
  - InReady = !SkidValid, registered-state only. It has no combinational path from OutReady.
- States, encoded by {OutValid, SkidValid}:
  - EMPTY (0,0): an input handshake loads OutReg → ONE.
  - ONE (1,0):
    - output handshake with no input handshake → EMPTY.
    - output handshake with an input handshake → ONE, with OutReg replaced.
    - input handshake with no output handshake → the new result goes to SkidReg → FULL.
    - neither → hold.
  - FULL (1,1): InReady = 0.
    - output handshake → SkidReg moves to OutReg → ONE.
    - otherwise hold.
- Order is strictly preserved. Each accepted immediate appears on Out exactly once.
- Flush: OutValid and SkidValid clear next cycle. An input handshake in the same cycle is discarded. Flush has priority over all transfers.
- Reset has priority over Flush and clears the same state as Flush.

## Timing
- Reset values: OutValid = 0, InReady = 1 in the cycle after Reset deasserts (InReady is 1 throughout reset), Out = 0, SkidReg = 0.
- Latency: one cycle from input handshake to OutValid when the block is EMPTY or draining.
- Throughput: one result per cycle while OutReady = 1.
- Out is stable while OutValid && !OutReady; it changes only after an output handshake.
- Reset mid-operation: all held data is lost and no partial result is emitted.
- Flush while FULL: both entries are dropped; InReady = 1 the next cycle.

## Structure
- Shared package holds the mode encodings (IMM_ZERO, IMM_SIGN, IMM_UPPER, IMM_BRANCH) and the default widths. The control unit reuses these encodings.
- One natural sub-module: imm_extend_core, purely combinational (In, Mode → extended value), instanced once at the input. SkidReg and OutReg store extended values.
- Handshake and skid logic live in the top module.

## Test plan
- After reset, In = 16'h8004, Mode = sign, InValid pulse, OutReady = 1 → next cycle OutValid = 1, Out = 32'hFFFF8004. Same In in zero mode → 32'h00008004 (no held value).
- In = 16'h1234 upper → 32'h12340000; In = 16'hFFFF branch → 32'hFFFFFFFC; In = 16'h7FFF branch → 32'h0001FFFC.
- OutReady = 0, three back-to-back inputs A, B, C → A on Out, B in skid, InReady = 0 and C is not accepted. Raise OutReady → Out sequence A, B, then C once re-presented; no loss, no duplication.
- FULL state plus Flush asserted with InValid = 1 → next cycle OutValid = 0, InReady = 1, nothing emitted.
- Reset asserted in the ONE state with OutReady = 0 → next cycle OutValid = 0, Out = 0.
- Parameter sweep IN_WIDTH = 8, OUT_WIDTH = 16, BR_SHIFT = 1: In = 8'h80 sign → 16'hFF80, branch → 16'hFF00, upper → 16'h8000.
